// File: rtl/alu.sv
// 8-bit registered ALU: ADD/SUB/AND/OR/NOT plus optional XOR/SHL/SHR.
// Extended opcodes 5..7 are enabled by defining ALU_EXT_OPS_EN.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] opcode,
    output logic [7:0] out,
    output logic       zero,
    output logic       carry
);

    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] res_d;
    logic       carry_d;

    // Ninth bit of the widened difference is the borrow (set iff a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res_d   = 8'h00;
        carry_d = 1'b0;
        case (opcode)
            3'd0: begin
                res_d   = sum[7:0];
                carry_d = sum[8];
            end
            3'd1: begin
                res_d   = diff[7:0];
                carry_d = diff[8];
            end
            3'd2: res_d = a & b;
            3'd3: res_d = a | b;
            3'd4: res_d = ~a;
`ifdef ALU_EXT_OPS_EN
            3'd5: res_d = a ^ b;
            3'd6: begin
                res_d   = {a[6:0], 1'b0};
                carry_d = a[7];
            end
            3'd7: begin
                res_d   = {1'b0, a[7:1]};
                carry_d = a[0];
            end
`else
            3'd5, 3'd6, 3'd7: begin
                res_d   = 8'h00;
                carry_d = 1'b0;
            end
`endif
            default: begin
                res_d   = 8'h00;
                carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= 8'h00;
            zero  <= 1'b1;
            carry <= 1'b0;
        end else begin
            out   <= res_d;
            zero  <= (res_d == 8'h00);
            carry <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes hand-computed results, monitor pops
// and compares one edge later. Expected values follow ALU_EXT_OPS_EN.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opcode;
    logic [7:0] out;
    logic       zero;
    logic       carry;

    typedef struct {
        logic [7:0] out;
        logic       zero;
        logic       carry;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .out    (out),
        .zero   (zero),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] eo, input logic ez,
                         input logic ec);
        checks++;
        if (out !== eo || zero !== ez || carry !== ec) begin
            errors++;
            $display("FAIL %s: got out=%h zero=%b carry=%b, expected out=%h zero=%b carry=%b",
                     name, out, zero, carry, eo, ez, ec);
        end
    endtask

    // Drive one vector at the falling edge and queue its expected result.
    task automatic vec(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop,
                       input logic [7:0] eo, input logic ez, input logic ec,
                       input string name);
        exp_t e;
        @(negedge clk);
        rst    = 1'b0;
        a      = va;
        b      = vb;
        opcode = vop;
        e.out   = eo;
        e.zero  = ez;
        e.carry = ec;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Monitor: result must appear exactly one rising edge after the drive.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.name, e.out, e.zero, e.carry);
        end
    end

    initial begin
        rst    = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        opcode = 3'd0;

        // Asynchronous reset before any clock edge.
        #1;
        rst    = 1'b1;
        a      = 8'hAA;
        b      = 8'h55;
        opcode = 3'd0;
        #2;
        check("rst_async", 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", 8'h00, 1'b1, 1'b0);
            a      = a + 8'h11;
            opcode = 3'(i + 1);
        end

        vec(8'h0F, 8'h01, 3'd0, 8'h10, 1'b0, 1'b0, "add_0f_01");
        vec(8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, "add_ff_01_wrap");
        vec(8'h05, 8'h07, 3'd1, 8'hFE, 1'b0, 1'b1, "sub_05_07_borrow");
        vec(8'h07, 8'h05, 3'd1, 8'h02, 1'b0, 1'b0, "sub_07_05");
        vec(8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, "and_f0_3c");
        vec(8'hF0, 8'h3C, 3'd3, 8'hFC, 1'b0, 1'b0, "or_f0_3c");
        vec(8'hF0, 8'h3C, 3'd4, 8'h0F, 1'b0, 1'b0, "not_f0");
`ifdef ALU_EXT_OPS_EN
        vec(8'hF0, 8'h3C, 3'd5, 8'hCC, 1'b0, 1'b0, "xor_f0_3c");
        vec(8'h81, 8'h00, 3'd6, 8'h02, 1'b0, 1'b1, "shl_81");
        vec(8'h81, 8'h00, 3'd7, 8'h40, 1'b0, 1'b1, "shr_81");
        vec(8'h7F, 8'hFF, 3'd6, 8'hFE, 1'b0, 1'b0, "shl_7f");
        vec(8'h01, 8'hFF, 3'd7, 8'h00, 1'b1, 1'b1, "shr_01_zero");
`else
        vec(8'hF0, 8'h3C, 3'd5, 8'h00, 1'b1, 1'b0, "op5_disabled");
        vec(8'h81, 8'h00, 3'd6, 8'h00, 1'b1, 1'b0, "op6_disabled");
        vec(8'h81, 8'h00, 3'd7, 8'h00, 1'b1, 1'b0, "op7_disabled");
        vec(8'hFF, 8'hFF, 3'd7, 8'h00, 1'b1, 1'b0, "op7_disabled_ff");
`endif
        vec(8'h33, 8'h33, 3'd1, 8'h00, 1'b1, 1'b0, "sub_equal_zero");
        vec(8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1, "add_80_80");
        vec(8'hFF, 8'h12, 3'd4, 8'h00, 1'b1, 1'b0, "not_ff_zero");
        vec(8'h00, 8'h01, 3'd1, 8'hFF, 1'b0, 1'b1, "sub_00_01");
        vec(8'h12, 8'h34, 3'd0, 8'h46, 1'b0, 1'b0, "add_12_34");

        // Reset between edges clears at once and overrides the pending load.
        @(negedge clk);
        a      = 8'h0F;
        b      = 8'h01;
        opcode = 3'd0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_async", 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("rst_over_edge", 8'h00, 1'b1, 1'b0);

        // First load after release lands on the first rising edge with rst low.
        vec(8'h0F, 8'h01, 3'd0, 8'h10, 1'b0, 1'b0, "first_after_release");
        vec(8'hC3, 8'h3C, 3'd3, 8'hFF, 1'b0, 1'b0, "or_c3_3c");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
